fetch_decode_buffer: RTL and testbench
======================================

# fetch_decode_buffer

Instruction fetch-to-decode queue: captures the PC, instruction word and fetch address-error flag that instruction memory produces each cycle and presents them, in order, to the decode stage under a valid/ready handshake. It sits directly downstream of instruction memory and drives that block's `pcStall`. It absorbs decode stalls without a combinational ready path back into the PC. It also fences the fetch stream after a faulting fetch until the pipeline flushes.

## Interface
- `DEPTH`, 2, queue entries; legal values 2, 4, 8.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low; asserting it clears all state immediately.
- `f_valid`  in  1  fetch word valid. Low while fetch is hanging, or when PC and instruction read 0.
- `f_pc`  in  32  byte PC of the fetched word.
- `f_instr`  in  32  fetched instruction word.
- `f_exc`  in  1  fetch address error: PC is out of range 0x3000..0x4FFC or misaligned.
- `f_stall`  out  1  to instruction memory `pcStall`; fetch must hold PC while high.
- `flush`  in  1  synchronous pipeline flush (exception entry, eret, redirect).
- `d_ready`  in  1  decode accepts head entry this cycle.
- `d_valid`  out  1  head entry present.
- `d_pc`  out  32  head PC.
- `d_instr`  out  32  head instruction.
- `d_exc`  out  1  head entry carries a fetch exception.
- `d_exc_code`  out  5  4 (AdEL) when `d_exc` is high, else 0.
- `occupancy`  out  log2(DEPTH)+1  entries held.

## Operation
- Circular FIFO with read pointer, write pointer and count. Pointers are log2(DEPTH) bits and wrap modulo DEPTH.
- Enqueue condition: `f_valid && !f_stall && !flush`.
- Dequeue condition: `d_valid && d_ready && !flush`.
- An entry stores {pc, instr, exc}. If `f_exc` is high at enqueue, the stored instr is forced to 0 (nop) and exc is set to 1.
- Fence state:
  - Set on enqueue of an entry with exc=1.
  - While set, no further enqueues occur and `f_stall` is held high.
  - Cleared only by `flush` or `reset`.
- `f_stall = (count == DEPTH) || fence`. It is registered-state-only and never depends on `d_ready`.
- Outputs are combinational from the head entry.
- When `d_valid=0`: `d_pc=0`, `d_instr=0`, `d_exc=0`, `d_exc_code=0`. This is a bubble.
- Flush has highest priority. Count, both pointers and fence clear to 0. A same-cycle enqueue and dequeue are both suppressed.
- Simultaneous enqueue and dequeue: count is unchanged and both pointers advance. This is legal at any count 1..DEPTH-1. At count==DEPTH no enqueue occurs because `f_stall` is high.
- Dequeue at count 0 cannot occur because `d_valid` is low. `f_valid` with `f_stall` high is ignored, and fetch re-presents the same word.

## Timing
- Reset state: count 0, pointers 0, fence 0. Consequently `d_valid=0`, all data outputs 0, `f_stall=0`, `occupancy=0`.
- Reset release: the first enqueue can occur on the first rising edge after `reset` goes high.
- Latency: a word enqueued at edge N appears on `d_*` after edge N when the queue was empty. There is no same-cycle bypass.
- Throughput: one word per cycle sustained while `d_ready` stays high.
- `f_stall` rises in the cycle after the enqueue that fills the queue, and falls in the cycle after the first dequeue from full.
- Flush: after the flush edge, `d_valid=0` and `f_stall=0`. The next enqueue can occur on the following edge.
- Reset asserted mid-operation: all entries are discarded asynchronously and outputs go to reset values without waiting for a clock edge.

## Test plan
- Streaming: after reset, fetch 0x3000/0x3004/0x3008 with `d_ready=1` every cycle. Required: `d_pc` shows 0x3000, 0x3004, 0x3008 on consecutive cycles, one cycle behind, with `occupancy` holding at 1.
- Back-pressure: with `d_ready=0` and DEPTH=2, enqueue 0x3000 and 0x3004, offering 0x3008. Required: `f_stall=1`, `occupancy=2`, `d_pc=0x3000`. Raise `d_ready` for one cycle. Required: `d_pc=0x3004`, then 0x3008 is accepted and ordering is preserved.
- Fetch fault: offer `f_pc=0x5000`, `f_exc=1`, `f_instr=0x8C010000`. Required: `d_exc=1`, `d_exc_code=4`, `d_instr=0`, `d_pc=0x5000`. `f_stall` stays 1 even after the entry is dequeued, and stays so until `flush`.
- Flush while full: with two entries held, assert `flush` together with `d_ready=1` and `f_valid=1`. Required: after the flush edge `occupancy=0`, `d_valid=0`, `f_stall=0`, and no entry is consumed or captured.
- Async reset: with three entries in a DEPTH=4 queue, pulse `reset` low between clock edges. Required: `d_valid`, `f_stall` and `occupancy` go to 0 immediately.
- Wrap-around (DEPTH=4): run 10 words with `d_ready` toggling every cycle. Required: all 10 PCs emerge in order, none are duplicated or dropped, and `occupancy` never exceeds 4.

Source files
------------

// File: rtl/fetch_decode_buffer.sv
// Fetch-to-decode instruction queue: circular FIFO of {pc, instr, exc} with a
// fault fence that holds fetch stalled from a faulting fetch until flush.
module fetch_decode_buffer #(
  parameter int DEPTH = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    f_valid,
  input  logic [31:0]             f_pc,
  input  logic [31:0]             f_instr,
  input  logic                    f_exc,
  output logic                    f_stall,
  input  logic                    flush,
  input  logic                    d_ready,
  output logic                    d_valid,
  output logic [31:0]             d_pc,
  output logic [31:0]             d_instr,
  output logic                    d_exc,
  output logic [4:0]              d_exc_code,
  output logic [$clog2(DEPTH):0]  occupancy
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);
  localparam logic [AW:0] ZERO_COUNT = (AW + 1)'(0);
  localparam logic [4:0]  ADEL_CODE  = 5'd4;

  logic [31:0]      pc_mem    [DEPTH];
  logic [31:0]      instr_mem [DEPTH];
  logic [DEPTH-1:0] exc_mem;
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [AW:0]      count;
  logic             fence;
  logic             enq;
  logic             deq;

  // Stall comes only from registered state, so no ready path reaches the PC.
  assign f_stall   = (count == FULL_COUNT) || fence;
  assign d_valid   = (count != ZERO_COUNT);
  assign enq       = f_valid && !f_stall && !flush;
  assign deq       = d_valid && d_ready && !flush;
  assign occupancy = count;

  // Queue control: pointers, entry count and fault fence.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr <= {AW{1'b0}};
      wr_ptr <= {AW{1'b0}};
      count  <= ZERO_COUNT;
      fence  <= 1'b0;
    end else if (flush) begin
      rd_ptr <= {AW{1'b0}};
      wr_ptr <= {AW{1'b0}};
      count  <= ZERO_COUNT;
      fence  <= 1'b0;
    end else begin
      if (enq) begin
        wr_ptr <= wr_ptr + AW'(1'b1);
        if (f_exc) begin
          fence <= 1'b1;
        end
      end
      if (deq) begin
        rd_ptr <= rd_ptr + AW'(1'b1);
      end
      case ({enq, deq})
        2'b10:   count <= count + (AW + 1)'(1'b1);
        2'b01:   count <= count - (AW + 1)'(1'b1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage; a faulting fetch is stored as a nop carrying the exc flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem[i]    <= 32'h0000_0000;
        instr_mem[i] <= 32'h0000_0000;
      end
      exc_mem <= {DEPTH{1'b0}};
    end else if (enq) begin
      pc_mem[wr_ptr]    <= f_pc;
      instr_mem[wr_ptr] <= f_exc ? 32'h0000_0000 : f_instr;
      exc_mem[wr_ptr]   <= f_exc;
    end
  end

  // Head entry presentation; an empty queue shows an all-zero bubble.
  always_comb begin
    d_pc       = 32'h0000_0000;
    d_instr    = 32'h0000_0000;
    d_exc      = 1'b0;
    d_exc_code = 5'd0;
    if (d_valid) begin
      d_pc       = pc_mem[rd_ptr];
      d_instr    = instr_mem[rd_ptr];
      d_exc      = exc_mem[rd_ptr];
      d_exc_code = exc_mem[rd_ptr] ? ADEL_CODE : 5'd0;
    end else begin
      d_pc       = 32'h0000_0000;
      d_instr    = 32'h0000_0000;
      d_exc      = 1'b0;
      d_exc_code = 5'd0;
    end
  end

endmodule

// File: tb/tb_fetch_decode_buffer.sv
// Bench for fetch_decode_buffer: DEPTH=2 and DEPTH=4 instances share stimulus
// and are compared every cycle against a list-based reference model.
module tb_fetch_decode_buffer;

  logic        clk;
  logic        reset;
  logic        f_valid;
  logic [31:0] f_pc;
  logic [31:0] f_instr;
  logic        f_exc;
  logic        flush;
  logic        d_ready;

  logic        fs    [2];
  logic        dv    [2];
  logic [31:0] dpc   [2];
  logic [31:0] dins  [2];
  logic        dexc  [2];
  logic [4:0]  dcode [2];
  logic [1:0]  occ2;
  logic [2:0]  occ4;

  int tests;
  int fails;

  // Reference model: head of each list is element 0.
  int          depth_of [2];
  int          m_cnt    [2];
  bit          m_fence  [2];
  logic [31:0] m_pc     [2][8];
  logic [31:0] m_instr  [2][8];
  logic        m_exc    [2][8];

  fetch_decode_buffer #(.DEPTH(2)) dut2 (
    .clk(clk), .reset(reset), .f_valid(f_valid), .f_pc(f_pc), .f_instr(f_instr),
    .f_exc(f_exc), .f_stall(fs[0]), .flush(flush), .d_ready(d_ready),
    .d_valid(dv[0]), .d_pc(dpc[0]), .d_instr(dins[0]), .d_exc(dexc[0]),
    .d_exc_code(dcode[0]), .occupancy(occ2)
  );

  fetch_decode_buffer #(.DEPTH(4)) dut4 (
    .clk(clk), .reset(reset), .f_valid(f_valid), .f_pc(f_pc), .f_instr(f_instr),
    .f_exc(f_exc), .f_stall(fs[1]), .flush(flush), .d_ready(d_ready),
    .d_valid(dv[1]), .d_pc(dpc[1]), .d_instr(dins[1]), .d_exc(dexc[1]),
    .d_exc_code(dcode[1]), .occupancy(occ4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s[D%0d]: observed %h expected %h", tag, depth_of[k], obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < 2; k++) begin
      m_cnt[k]   = 0;
      m_fence[k] = 1'b0;
    end
  endtask

  task automatic check_all();
    logic [31:0] occ;
    for (int k = 0; k < 2; k++) begin
      occ = (k == 0) ? 32'(occ2) : 32'(occ4);
      chk("occupancy", k, occ, 32'(m_cnt[k]));
      chk("d_valid", k, 32'(dv[k]), (m_cnt[k] > 0) ? 32'd1 : 32'd0);
      chk("f_stall", k, 32'(fs[k]), ((m_cnt[k] == depth_of[k]) || m_fence[k]) ? 32'd1 : 32'd0);
      chk("d_pc", k, dpc[k], (m_cnt[k] > 0) ? m_pc[k][0] : 32'd0);
      chk("d_instr", k, dins[k], (m_cnt[k] > 0) ? m_instr[k][0] : 32'd0);
      chk("d_exc", k, 32'(dexc[k]), (m_cnt[k] > 0) ? 32'(m_exc[k][0]) : 32'd0);
      chk("d_exc_code", k, 32'(dcode[k]), ((m_cnt[k] > 0) && m_exc[k][0]) ? 32'd4 : 32'd0);
    end
  endtask

  task automatic model_update();
    bit stall;
    for (int k = 0; k < 2; k++) begin
      if (flush) begin
        m_cnt[k]   = 0;
        m_fence[k] = 1'b0;
      end else begin
        stall = (m_cnt[k] == depth_of[k]) || m_fence[k];
        if (m_cnt[k] > 0 && d_ready) begin
          for (int i = 0; i < 7; i++) begin
            m_pc[k][i]    = m_pc[k][i+1];
            m_instr[k][i] = m_instr[k][i+1];
            m_exc[k][i]   = m_exc[k][i+1];
          end
          m_cnt[k]--;
        end
        if (f_valid && !stall) begin
          m_pc[k][m_cnt[k]]    = f_pc;
          m_instr[k][m_cnt[k]] = f_exc ? 32'd0 : f_instr;
          m_exc[k][m_cnt[k]]   = f_exc;
          m_cnt[k]++;
          if (f_exc) m_fence[k] = 1'b1;
        end
      end
    end
  endtask

  task automatic step();
    check_all();
    model_update();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int idx;
    int guard;
    bit acc;
    tests = 0;
    fails = 0;
    depth_of[0] = 2;
    depth_of[1] = 4;
    model_clear();
    reset = 1'b0; f_valid = 1'b0; f_pc = 32'd0; f_instr = 32'd0;
    f_exc = 1'b0; flush = 1'b0; d_ready = 1'b0;

    // Reset state, then release between edges.
    #1;
    check_all();
    @(posedge clk); #3;
    reset = 1'b1;
    @(posedge clk); #1;

    // Streaming with decode always ready.
    d_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      f_valid = 1'b1; f_pc = 32'h3000 + 32'(4 * i); f_instr = $urandom;
      step();
      chk("stream_pc", 0, dpc[0], 32'h3000 + 32'(4 * i));
    end
    f_valid = 1'b0;
    step(); step();

    // Back-pressure on the DEPTH=2 queue.
    d_ready = 1'b0; f_valid = 1'b1;
    f_pc = 32'h3000; f_instr = $urandom; step();
    f_pc = 32'h3004; f_instr = $urandom; step();
    f_pc = 32'h3008; f_instr = $urandom; step();
    chk("bp_stall", 0, 32'(fs[0]), 32'd1);
    chk("bp_head", 0, dpc[0], 32'h3000);
    d_ready = 1'b1; step();
    chk("bp_next", 0, dpc[0], 32'h3004);
    d_ready = 1'b0; step();
    f_valid = 1'b0; d_ready = 1'b1;
    for (int i = 0; i < 5; i++) step();

    // Fetch fault fences the stream until flush.
    d_ready = 1'b0; f_valid = 1'b1; f_exc = 1'b1;
    f_pc = 32'h5000; f_instr = 32'h8C01_0000; step();
    chk("fault_exc", 0, 32'(dexc[0]), 32'd1);
    chk("fault_code", 0, 32'(dcode[0]), 32'd4);
    chk("fault_instr", 0, dins[0], 32'd0);
    f_exc = 1'b0; f_pc = 32'h3010; f_instr = $urandom;
    step();
    d_ready = 1'b1; step(); step();
    chk("fence_stall", 0, 32'(fs[0]), 32'd1);
    flush = 1'b1; step();
    flush = 1'b0; f_valid = 1'b0;
    chk("fence_clear", 0, 32'(fs[0]), 32'd0);
    step();

    // Flush while holding two entries, with ready and valid also high.
    d_ready = 1'b0; f_valid = 1'b1;
    f_pc = 32'h3000; step();
    f_pc = 32'h3004; step();
    flush = 1'b1; d_ready = 1'b1; f_pc = 32'h3008; step();
    flush = 1'b0; f_valid = 1'b0;
    chk("flush_occ", 1, 32'(occ4), 32'd0);
    step();

    // Asynchronous reset with three entries in the DEPTH=4 queue.
    d_ready = 1'b0; f_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      f_pc = 32'h3020 + 32'(4 * i); f_instr = $urandom; step();
    end
    f_valid = 1'b0;
    check_all();
    #2 reset = 1'b0;
    #1 model_clear();
    chk("areset_occ", 1, 32'(occ4), 32'd0);
    check_all();
    #1 reset = 1'b1;
    step();

    // Wrap-around: 10 words into DEPTH=4 with ready toggling every cycle.
    idx = 0; guard = 0;
    while (idx < 10 && guard < 100) begin
      f_valid = 1'b1; f_pc = 32'h3100 + 32'(4 * idx); f_instr = $urandom;
      d_ready = guard[0];
      acc = !((m_cnt[1] == 4) || m_fence[1]);
      step();
      if (acc) idx++;
      guard++;
    end
    chk("wrap_accepted", 1, 32'(idx), 32'd10);
    f_valid = 1'b0; d_ready = 1'b1;
    for (int i = 0; i < 6; i++) step();

    // Randomized traffic including faults and flushes.
    for (int i = 0; i < 600; i++) begin
      f_valid = ($urandom % 4) != 0;
      d_ready = ($urandom % 3) != 0;
      f_exc   = ($urandom % 20) == 0;
      flush   = ($urandom % 25) == 0;
      f_pc    = 32'h3000 + 32'(4 * ($urandom % 2048));
      f_instr = $urandom;
      step();
    end
    flush = 1'b0; f_valid = 1'b0;
    check_all();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
